alu_share_sched: RTL and testbench

- Schedules and shares one combinational 32-bit ALU (ports a, b, op[2:0], out, zero, overflow, cout, less) between two requesters.
- Requests are accepted with a valid/ready handshake and granted round-robin. Operands and op are held stable on the ALU for one evaluation cycle, and result plus flags are registered.
- Each response goes back to the winning requester through its own valid/ready handshake.
- Sits between two client blocks (e.g. a decode stage and a test/debug port) and the ALU instance.

---
 rtl/alu_share_sched.sv | 147 ++++++++++++++
 tb/tb_alu_share_sched.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_sched.sv
// alu_share_sched: round-robin scheduler sharing one combinational ALU between two requesters.
// Latency: accept at cycle t, rspN_valid first high at t+2; one operation in flight, 3 cycles minimum each.
// Backpressure: a held response (rspN_ready low) stalls the block; no request is accepted until it completes.
//
// Ports:
//   clk, rst                          rising-edge clock, synchronous active-high reset
//   reqN_valid/ready, reqN_a/b/op     request handshake and operands per requester (N = 0, 1)
//   rspN_valid/ready                  response handshake per requester
//   rsp_data, rsp_flags               registered result and {zero, overflow, cout, less}, shared by both ports
//   alu_a, alu_b, alu_op              registered operands driven to the external ALU
//   alu_out, alu_zero/overflow/cout/less  combinational ALU result and flags
// Optional: define ALU_SHARE_STATS_EN to add saturating counters ops0_cnt, ops1_cnt, busy_cnt.
module alu_share_sched #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [3:0]       rsp_flags,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_cout,
  input  logic             alu_less
`ifdef ALU_SHARE_STATS_EN
  ,
  output logic [15:0]      ops0_cnt,
  output logic [15:0]      ops1_cnt,
  output logic [15:0]      busy_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   last_grant;   // requester served most recently
  logic   gnt;          // requester owning the in-flight operation
  logic   grant_vld;
  logic   grant_sel;
  logic   rsp_done;

  // Handshake outputs are gated by rst so that nothing is accepted or
  // delivered in a reset cycle, whatever state the register still holds.
  always_comb begin
    state_nxt  = state;
    grant_vld  = 1'b0;
    grant_sel  = 1'b0;
    rsp_done   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (req0_valid && req1_valid) begin
            grant_vld = 1'b1;
            grant_sel = ~last_grant;
          end else if (req0_valid) begin
            grant_vld = 1'b1;
            grant_sel = 1'b0;
          end else if (req1_valid) begin
            grant_vld = 1'b1;
            grant_sel = 1'b1;
          end
          if (grant_vld) begin
            req0_ready = ~grant_sel;
            req1_ready = grant_sel;
            state_nxt  = EXEC;
          end
        end
        EXEC: state_nxt = RESP;
        RESP: begin
          rsp0_valid = ~gnt;
          rsp1_valid = gnt;
          rsp_done   = gnt ? rsp1_ready : rsp0_ready;
          if (rsp_done) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_data   <= '0;
      rsp_flags  <= '0;
    end else begin
      state <= state_nxt;
      // grant_vld is only ever raised in IDLE
      if (grant_vld) begin
        gnt    <= grant_sel;
        alu_a  <= grant_sel ? req1_a  : req0_a;
        alu_b  <= grant_sel ? req1_b  : req0_b;
        alu_op <= grant_sel ? req1_op : req0_op;
      end
      if (state == EXEC) begin
        rsp_data  <= alu_out;
        rsp_flags <= {alu_zero, alu_overflow, alu_cout, alu_less};
      end
      if (rsp_done) last_grant <= gnt;
    end
  end

`ifdef ALU_SHARE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ops0_cnt <= '0;
      ops1_cnt <= '0;
      busy_cnt <= '0;
    end else begin
      if (rsp_done && !gnt && ops0_cnt != 16'hFFFF) ops0_cnt <= ops0_cnt + 16'd1;
      if (rsp_done &&  gnt && ops1_cnt != 16'hFFFF) ops1_cnt <= ops1_cnt + 16'd1;
      if (state != IDLE && busy_cnt != 16'hFFFF)    busy_cnt <= busy_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_sched.sv
// Bench for alu_share_sched: stands in for the ALU, drives directed and random requests,
// and checks every cycle against a transaction-level model (one op in flight, result due two cycles after accept).
module tb_alu_share_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 0, req1_valid = 0, rsp0_ready = 1, rsp1_ready = 1;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [2:0]  req0_op = 0, req1_op = 0;
  logic [31:0] rsp_data, alu_a, alu_b, alu_out;
  logic [3:0]  rsp_flags;
  logic [2:0]  alu_op;
  logic        alu_zero, alu_overflow, alu_cout, alu_less;
`ifdef ALU_SHARE_STATS_EN
  logic [15:0] ops0_cnt, ops1_cnt, busy_cnt;
`endif

  int n_chk = 0, n_pass = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  alu_share_sched #(.WIDTH(32), .OPW(3)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow), .alu_cout(alu_cout), .alu_less(alu_less)
`ifdef ALU_SHARE_STATS_EN
    , .ops0_cnt(ops0_cnt), .ops1_cnt(ops1_cnt), .busy_cnt(busy_cnt)
`endif
  );

  // Reference ALU: returns {zero, overflow, cout, less, out}
  function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    logic [32:0] s;
    logic [31:0] r;
    logic ov, c, lt;
    lt = $signed(a) < $signed(b);
    r = 32'd0; ov = 1'b0; c = 1'b0; s = 33'd0;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0]; c = s[32];
        ov = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'b110: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0]; c = s[32];
        ov = (a[31] != b[31]) && (r[31] != a[31]);
      end
      3'b111: r = {31'd0, lt};
      default: r = 32'd0;
    endcase
    return {(r == 32'd0), ov, c, lt, r};
  endfunction

  always_comb {alu_zero, alu_overflow, alu_cout, alu_less, alu_out} = alu_ref(alu_a, alu_b, alu_op);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
  endtask

  // ---------------- transaction-level model + per-cycle compare ----------------
  bit          m_busy = 0, m_own = 0, m_last = 1;
  int          m_acc = 0;
  logic [31:0] m_a = 0, m_b = 0;
  logic [2:0]  m_op = 0;
  logic [35:0] m_rsp = 0;

  always @(negedge clk) begin
    bit g_ok, g, e_r0, e_r1, e_v0, e_v1;
    g_ok = 0; g = 0; e_r0 = 0; e_r1 = 0; e_v0 = 0; e_v1 = 0;
    if (!rst) begin
      if (!m_busy) begin
        if (req0_valid && req1_valid) begin g_ok = 1; g = !m_last; end
        else if (req0_valid) begin g_ok = 1; g = 0; end
        else if (req1_valid) begin g_ok = 1; g = 1; end
        e_r0 = g_ok && !g;
        e_r1 = g_ok && g;
      end else if (cyc >= m_acc + 2) begin
        e_v0 = !m_own;
        e_v1 = m_own;
      end
    end
    chk("m_req0_ready", {31'd0, req0_ready}, {31'd0, e_r0});
    chk("m_req1_ready", {31'd0, req1_ready}, {31'd0, e_r1});
    chk("m_rsp0_valid", {31'd0, rsp0_valid}, {31'd0, e_v0});
    chk("m_rsp1_valid", {31'd0, rsp1_valid}, {31'd0, e_v1});
    chk("m_alu_a", alu_a, m_a);
    chk("m_alu_b", alu_b, m_b);
    chk("m_alu_op", {29'd0, alu_op}, {29'd0, m_op});
    chk("m_rsp_data", rsp_data, m_rsp[31:0]);
    chk("m_rsp_flags", {28'd0, rsp_flags}, {28'd0, m_rsp[35:32]});
    // advance model to the next clock edge
    if (rst) begin
      m_busy = 0; m_last = 1; m_a = 0; m_b = 0; m_op = 0; m_rsp = 0;
    end else if (g_ok) begin
      m_busy = 1; m_acc = cyc; m_own = g;
      m_a  = g ? req1_a  : req0_a;
      m_b  = g ? req1_b  : req0_b;
      m_op = g ? req1_op : req0_op;
    end else if (m_busy && cyc == m_acc + 1) begin
      m_rsp = alu_ref(m_a, m_b, m_op);
    end else if ((e_v0 && rsp0_ready) || (e_v1 && rsp1_ready)) begin
      m_busy = 0; m_last = m_own;
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit p, input bit v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    if (p) begin req1_valid = v; req1_a = a; req1_b = b; req1_op = op; end
    else   begin req0_valid = v; req0_a = a; req0_b = b; req0_op = op; end
  endtask

  task automatic run_one(input bit p, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input logic [31:0] ed, input logic [3:0] ef, input string nm);
    tick();
    drive(p, 1, a, b, op);
    @(negedge clk);
    chk({nm, "_ready"}, {31'd0, p ? req1_ready : req0_ready}, 32'd1);
    chk({nm, "_other_ready"}, {31'd0, p ? req0_ready : req1_ready}, 32'd0);
    tick();
    drive(p, 0, a, b, op);
    @(negedge clk);
    chk({nm, "_valid_t1"}, {31'd0, p ? rsp1_valid : rsp0_valid}, 32'd0);
    tick();
    @(negedge clk);
    chk({nm, "_valid_t2"}, {31'd0, p ? rsp1_valid : rsp0_valid}, 32'd1);
    chk({nm, "_other_valid"}, {31'd0, p ? rsp0_valid : rsp1_valid}, 32'd0);
    chk({nm, "_data"}, rsp_data, ed);
    chk({nm, "_flags"}, {28'd0, rsp_flags}, {28'd0, ef});
    tick();
    @(negedge clk);
    chk({nm, "_valid_done"}, {31'd0, p ? rsp1_valid : rsp0_valid}, 32'd0);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 3));
      1:       return 32'h8000_0000 | 32'($urandom_range(0, 1));
      2:       return 32'h7FFF_FFFF - 32'($urandom_range(0, 1));
      default: return $urandom;
    endcase
  endfunction

  logic [2:0] op_tab [5] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};

  initial begin
    int gp[$];
    int gc[$];
    logic [31:0] rd[$];
    logic [3:0]  rf[$];
    // reset
    repeat (3) tick();
    @(negedge clk);
    chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    tick();
    rst = 0;
    tick();

    run_one(0, 32'h0000_7F55, 32'h0000_0DD9, 3'b010, 32'h0000_8D2E, 4'b0000, "add0");
    run_one(1, 32'h0000_0DD9, 32'h0000_7F55, 3'b110, 32'hFFFF_8E84, 4'b0001, "sub1");

    // fairness: both valid continuously
    tick();
    drive(0, 1, 32'h0000_7F55, 32'h0000_0DD9, 3'b111);
    drive(1, 1, 32'h0000_0DD9, 32'h0000_7F55, 3'b111);
    for (int k = 0; k < 20 && gp.size() < 4; k++) begin
      @(negedge clk);
      if (req0_ready) begin gp.push_back(0); gc.push_back(cyc); end
      if (req1_ready) begin gp.push_back(1); gc.push_back(cyc); end
      if (rsp0_valid || rsp1_valid) begin rd.push_back(rsp_data); rf.push_back(rsp_flags); end
      if (gp.size() < 4) tick();
    end
    tick();
    req0_valid = 0; req1_valid = 0;
    chk("rr_grants", 32'(gp.size()), 32'd4);
    chk("rr_rsps", 32'(rd.size()), 32'd3);
    if (gp.size() == 4 && rd.size() == 3) begin
      for (int i = 0; i < 4; i++) chk("rr_order", 32'(gp[i]), 32'(i % 2));
      for (int i = 0; i < 3; i++) begin
        chk("rr_spacing", 32'(gc[i+1] - gc[i]), 32'd3);
        chk("rr_data", rd[i], 32'(i % 2));
        chk("rr_less", {31'd0, rf[i][0]}, 32'(i % 2));
      end
    end
    repeat (4) tick();

    // response backpressure on port 0
    rsp0_ready = 0;
    drive(0, 1, 32'd1, 32'd2, 3'b010);
    @(negedge clk);
    chk("bp_accept", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 0;
    req1_valid = 1;
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid_hold", {31'd0, rsp0_valid}, 32'd1);
      chk("bp_data_hold", rsp_data, 32'd3);
      chk("bp_ready_low", {30'd0, req1_ready, req0_ready}, 32'd0);
      tick();
    end
    rsp0_ready = 1;
    req1_valid = 0;
    @(negedge clk);
    chk("bp_valid_last", {31'd0, rsp0_valid}, 32'd1);
    tick();
    @(negedge clk);
    chk("bp_valid_done", {31'd0, rsp0_valid}, 32'd0);

    // reset while in EXEC
    tick();
    drive(0, 1, 32'd5, 32'd5, 3'b110);
    @(negedge clk);
    chk("rx_accept", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 0;
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    chk("rx_valids", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("rx_data", rsp_data, 32'd0);
    chk("rx_flags", {28'd0, rsp_flags}, 32'd0);
    chk("rx_alu_a", alu_a, 32'd0);
    chk("rx_alu_b", alu_b, 32'd0);
    chk("rx_alu_op", {29'd0, alu_op}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      chk("rx_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    end
    tick();
    drive(0, 1, 32'd9, 32'd4, 3'b001);
    drive(1, 1, 32'd7, 32'd3, 3'b000);
    @(negedge clk);
    chk("rx_first_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
    tick();
    req0_valid = 0; req1_valid = 0;
    repeat (4) tick();

    // randomized traffic, checked by the model
    for (int k = 0; k < 3000; k++) begin
      tick();
      rst        = ($urandom_range(0, 199) == 0);
      req0_valid = ($urandom_range(0, 9) < 6);
      req1_valid = ($urandom_range(0, 9) < 6);
      req0_a = rnd_operand(); req0_b = rnd_operand(); req0_op = op_tab[$urandom_range(0, 4)];
      req1_a = rnd_operand(); req1_b = rnd_operand(); req1_op = op_tab[$urandom_range(0, 4)];
      rsp0_ready = ($urandom_range(0, 9) < 7);
      rsp1_ready = ($urandom_range(0, 9) < 7);
    end
    tick();
    rst = 0; req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
    repeat (5) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
